pong_match_ctrl: RTL
====================

# pong_match_ctrl

Match sequencer for the pong ball datapath. It sits between the player controls and the ball block. It drives the ball's reset, start and animate inputs, counts points from the ball's score flags, and enforces the serve, point-pause and game-over flow. Score and state outputs feed the score display and HUD logic.

## Interface

Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1–15.
- PAUSE_FRAMES, 120: number of in_ani_stb frames to hold after a point before serving is allowed.
- AUTO_SERVE, 0: if 1, the controller serves automatically when the point pause expires, without waiting for in_serve.

Ports:
- in_clock  input  1  base clock; the only clock.
- in_reset  input  1  asynchronous, active-high reset.
- in_ani_stb  input  1  one-cycle frame strobe.
- in_serve  input  1  serve/restart button; already debounced and synchronous, level.
- in_pause  input  1  level; freezes animation while high.
- in_left_score  input  1  ball flag: left player scored. Level, cleared by the ball on start.
- in_right_score  input  1  ball flag: right player scored. Level, cleared by the ball on start.
- out_ball_reset  output  1  one-cycle pulse that recentres the ball.
- out_ball_start  output  1  one-cycle pulse that launches the ball.
- out_ball_animate  output  1  animate enable to the ball.
- out_left_points  output  4  left player's score.
- out_right_points  output  4  right player's score.
- out_state  output  3  current FSM state encoding.
- out_winner  output  2  00 none, 01 left, 10 right, 11 draw.

## Operation

FSM states and encoding: INIT=0, SERVE_WAIT=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4.

- **INIT:** assert out_ball_reset for exactly one cycle, then go to SERVE_WAIT.
- **SERVE_WAIT:** on a serve edge (in_serve & ~serve_d), pulse out_ball_start and go to PLAY.
- **PLAY:** out_ball_animate = ~in_pause.
  - Score edges are in_left_score & ~left_d and in_right_score & ~right_d.
  - On any score edge, increment the matching point counter. Saturate at 15.
  - If a new count is ≥ WIN_SCORE, go to GAME_OVER and set out_winner. If both players reach WIN_SCORE in the same cycle, out_winner = 11.
  - Otherwise load the pause counter with PAUSE_FRAMES and go to POINT_PAUSE.
- **POINT_PAUSE:** out_ball_animate = 0.
  - Decrement the pause counter on each in_ani_stb.
  - When the counter reaches 0: if AUTO_SERVE, pulse out_ball_start and go to PLAY; otherwise go to SERVE_WAIT.
  - Serve edges during the pause are ignored.
- **GAME_OVER:** out_ball_animate = 0; scores and out_winner are held.
  - On a serve edge, clear both counters and out_winner, pulse out_ball_reset, and go to SERVE_WAIT.

Edge-detect registers (serve_d, left_d, right_d) update every cycle in every state. Score edges are honoured only in PLAY.

Both score edges in the same cycle (not expected from the ball): both counters increment, and the win check uses both new values.

Counter widths:
- Point counters: 4 bits.
- Pause counter: $clog2(PAUSE_FRAMES+1) bits.
- PAUSE_FRAMES=0 means leave POINT_PAUSE on the next in_ani_stb.

## Timing

- Reset (async) values:
  - State = INIT; out_ball_reset = 1 (held high while in_reset is asserted).
  - out_ball_start = 0, out_ball_animate = 0.
  - Both point counters = 0, out_winner = 00, pause counter = 0, edge registers = 0.
- First clock edge after reset release: out_ball_reset is still 1 and the state moves to SERVE_WAIT. On the next edge out_ball_reset = 0.
- out_ball_reset and out_ball_start are registered. Each is high for exactly the one cycle that follows the triggering edge/event cycle.
- The state changes on the same clock edge that raises the pulse.
- out_ball_animate is a combinational decode of the state register and in_pause.
- Score latency: a score edge at cycle N gives updated points, out_state and out_winner at cycle N+1.
- The pause count is measured in in_ani_stb pulses, not clock cycles.
- Reset asserted mid-pause or mid-play clears everything immediately; no pending pulse survives.

## Structure

- Shared include pong_defs.vh holds:
  - the state encodings (ST_INIT … ST_GAME_OVER);
  - the WINNER_* encodings;
  - the default WIN_SCORE, for the HUD to compare against.
- One sub-module: rise_edge (1-bit registered rising-edge detector with async reset), instantiated three times for serve, left score and right score.
- The FSM, counters and output pulses stay in pong_match_ctrl.

## Test plan

- **Reset then serve:** release reset. Require out_ball_reset = 1 for one cycle, then state = 1. Raise in_serve. Require out_ball_start = 1 for one cycle, state = 2, animate = 1.
- **Point and pause:** in PLAY, raise in_right_score. Require right_points = 1 and state = 3. Give 120 ani_stb pulses. Require state = 1, with no start pulse while AUTO_SERVE = 0.
- **Win:** play up to left_points = 6, then raise a left score edge. Require left_points = 7, winner = 01, state = 4. A serve edge then gives points = 0, winner = 00, a ball_reset pulse, and state = 1.
- **Pause input and ignored inputs:** hold in_pause in PLAY. Require animate = 0 and state unchanged. A serve edge during POINT_PAUSE must not change the state.
- **Simultaneous scores and AUTO_SERVE:** with WIN_SCORE=1, raise both score flags in the same cycle. Require winner = 11. With AUTO_SERVE=1 and PAUSE_FRAMES=2, a point is followed after 2 strobes by a start pulse and state = 2.
- **Reset mid-game:** assert in_reset in POINT_PAUSE with points 3:2. Require immediate INIT, points 0:0, out_ball_reset = 1.

Source files
------------

// File: rtl/pong_match_ctrl_pkg.sv
// Shared definitions for the pong match sequencer: state and winner encodings,
// the default winning score and a saturating point increment.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_SERVE_WAIT  = 3'd1,
        ST_PLAY        = 3'd2,
        ST_POINT_PAUSE = 3'd3,
        ST_GAME_OVER   = 3'd4
    } match_state_e;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;
    localparam logic [1:0] WINNER_DRAW  = 2'b11;

    localparam int unsigned DEFAULT_WIN_SCORE = 7;
    localparam logic [3:0]  POINTS_MAX        = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == POINTS_MAX) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_rise_edge.sv
// Registered rising-edge detector: remembers last cycle's level and flags a
// low-to-high change combinationally in the current cycle.
module pong_match_ctrl_rise_edge (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_sig,
    output logic out_edge
);

    logic sig_d;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= in_sig;
        end
    end

    assign out_edge = in_sig & ~sig_d;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: drives ball reset/start/animate, keeps the score and runs
// the serve, point-pause and game-over flow.
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DEFAULT_WIN_SCORE,
    parameter int unsigned PAUSE_FRAMES = 120,
    parameter int unsigned AUTO_SERVE   = 0
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_ani_stb,
    input  logic       in_serve,
    input  logic       in_pause,
    input  logic       in_left_score,
    input  logic       in_right_score,
    output logic       out_ball_reset,
    output logic       out_ball_start,
    output logic       out_ball_animate,
    output logic [3:0] out_left_points,
    output logic [3:0] out_right_points,
    output logic [2:0] out_state,
    output logic [1:0] out_winner
);

    // A zero-frame pause still needs a one-bit counter to exist.
    localparam int unsigned PW = (PAUSE_FRAMES > 0) ? $clog2(PAUSE_FRAMES + 1) : 1;
    localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_FRAMES);
    localparam logic [3:0]    WIN_LIMIT  = 4'(WIN_SCORE);

    match_state_e  state_q;
    logic [3:0]    left_q, right_q;
    logic [1:0]    winner_q;
    logic [PW-1:0] pause_q;
    logic          ball_reset_q, ball_start_q;

    logic serve_edge, left_edge, right_edge;
    logic [3:0] left_next, right_next;
    logic left_won, right_won;

    pong_match_ctrl_rise_edge u_serve_edge (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_sig   (in_serve),
        .out_edge (serve_edge)
    );

    pong_match_ctrl_rise_edge u_left_edge (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_sig   (in_left_score),
        .out_edge (left_edge)
    );

    pong_match_ctrl_rise_edge u_right_edge (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_sig   (in_right_score),
        .out_edge (right_edge)
    );

    always_comb begin
        left_next  = left_edge  ? sat_inc(left_q)  : left_q;
        right_next = right_edge ? sat_inc(right_q) : right_q;
        left_won   = left_edge  && (left_next  >= WIN_LIMIT);
        right_won  = right_edge && (right_next >= WIN_LIMIT);
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q      <= ST_INIT;
            ball_reset_q <= 1'b1;
            ball_start_q <= 1'b0;
            left_q       <= 4'd0;
            right_q      <= 4'd0;
            winner_q     <= WINNER_NONE;
            pause_q      <= '0;
        end else begin
            ball_reset_q <= 1'b0;
            ball_start_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    ball_reset_q <= 1'b1;
                    state_q      <= ST_SERVE_WAIT;
                end
                ST_SERVE_WAIT: begin
                    if (serve_edge) begin
                        ball_start_q <= 1'b1;
                        state_q      <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (left_edge || right_edge) begin
                        left_q  <= left_next;
                        right_q <= right_next;
                        if (left_won || right_won) begin
                            winner_q <= left_won ? (right_won ? WINNER_DRAW : WINNER_LEFT)
                                                 : WINNER_RIGHT;
                            state_q  <= ST_GAME_OVER;
                        end else begin
                            pause_q <= PAUSE_LOAD;
                            state_q <= ST_POINT_PAUSE;
                        end
                    end
                end
                ST_POINT_PAUSE: begin
                    if (in_ani_stb) begin
                        // A count of 0 or 1 means this strobe ends the pause.
                        if (pause_q <= PW'(1)) begin
                            pause_q <= '0;
                            if (AUTO_SERVE != 0) begin
                                ball_start_q <= 1'b1;
                                state_q      <= ST_PLAY;
                            end else begin
                                state_q <= ST_SERVE_WAIT;
                            end
                        end else begin
                            pause_q <= pause_q - PW'(1);
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (serve_edge) begin
                        left_q       <= 4'd0;
                        right_q      <= 4'd0;
                        winner_q     <= WINNER_NONE;
                        ball_reset_q <= 1'b1;
                        state_q      <= ST_SERVE_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign out_ball_reset   = ball_reset_q;
    assign out_ball_start   = ball_start_q;
    assign out_ball_animate = (state_q == ST_PLAY) && !in_pause;
    assign out_left_points  = left_q;
    assign out_right_points = right_q;
    assign out_state        = state_q;
    assign out_winner       = winner_q;

endmodule
